// File: rtl/fp16_pkg.sv
// ---------------------------------------------------------------------------
// fp16_pkg
// Shared definitions for the half-precision multiplier slice:
//   - FP16 field widths and bit positions ({sign, exp[5], mantissa[10]})
//   - widened exponent arithmetic constants used by the datapath
//   - controller FSM state encoding
// ---------------------------------------------------------------------------
package fp16_pkg;

   localparam int EXP_W    = 5;
   localparam int MAN_W    = 10;
   localparam int W        = 16;

   localparam int SIGN_BIT = 15;
   localparam int EXP_MSB  = 14;
   localparam int EXP_LSB  = 10;
   localparam int MAN_MSB  = 9;
   localparam int MAN_LSB  = 0;

   // Product of two {1.mantissa} significands.
   localparam int PROD_W   = 2 * (MAN_W + 1);

   // Exponent sums are formed two bits wider so a negative biased result
   // shows up in the top bit instead of wrapping into a valid exponent.
   localparam int EXP_X_W  = EXP_W + 2;
   localparam logic [EXP_X_W-1:0] EXP_BIAS = 7'd15;
   localparam logic [EXP_X_W-1:0] EXP_MAX  = 7'd31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/fmul_share_ctrl_fmul.sv
// ---------------------------------------------------------------------------
// FMul_HalfPrecision
// Purely combinational FP16 multiplier datapath. Zero/denormal operands
// (exponent field 0) give a zero product. The significand product is
// truncated; out-of-range exponents raise a flag and saturate to infinity
// (overflow) or flush to zero (underflow).
// Ports:
//   a, b       in  16 : FP16 operands
//   sign       out 1  : product sign
//   exponent   out 5  : biased product exponent
//   mantissa   out 10 : product mantissa (truncated)
//   overflow   out 1  : biased exponent above the representable range
//   underflow  out 1  : biased exponent at or below zero
// ---------------------------------------------------------------------------
module FMul_HalfPrecision
   import fp16_pkg::*;
(
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic             sign,
   output logic [EXP_W-1:0] exponent,
   output logic [MAN_W-1:0] mantissa,
   output logic             overflow,
   output logic             underflow
);

   logic [EXP_W-1:0]   exp_a;
   logic [EXP_W-1:0]   exp_b;
   logic [MAN_W:0]     sig_a;
   logic [MAN_W:0]     sig_b;
   logic [PROD_W-1:0]  prod;
   logic [EXP_X_W-1:0] exp_sum;
   logic               zero_in;
   logic               prod_lo_unused;

   assign exp_a   = a[EXP_MSB:EXP_LSB];
   assign exp_b   = b[EXP_MSB:EXP_LSB];
   assign sig_a   = {1'b1, a[MAN_MSB:MAN_LSB]};
   assign sig_b   = {1'b1, b[MAN_MSB:MAN_LSB]};
   assign prod    = {{(MAN_W+1){1'b0}}, sig_a} * {{(MAN_W+1){1'b0}}, sig_b};
   assign zero_in = (exp_a == '0) | (exp_b == '0);

   // A product of two 1.x significands lies in [1,4); the top bit selects
   // whether the exponent gets the extra +1 from normalisation.
   assign exp_sum = {2'b00, exp_a} + {2'b00, exp_b}
                  + {{(EXP_X_W-1){1'b0}}, prod[PROD_W-1]} - EXP_BIAS;

   // Bits below the kept mantissa are dropped: the datapath truncates.
   assign prod_lo_unused = |prod[MAN_W-1:0];

   // Classify the exponent and select the normalised mantissa window.
   always_comb begin
      sign      = a[SIGN_BIT] ^ b[SIGN_BIT];
      exponent  = '0;
      mantissa  = '0;
      overflow  = 1'b0;
      underflow = 1'b0;
      if (!zero_in) begin
         if (exp_sum[EXP_X_W-1] || (exp_sum == '0)) begin
            underflow = 1'b1;
         end else if (exp_sum >= EXP_MAX) begin
            overflow = 1'b1;
            exponent = '1;
         end else begin
            exponent = exp_sum[EXP_W-1:0];
            mantissa = prod[PROD_W-1] ? prod[PROD_W-2 -: MAN_W]
                                      : prod[PROD_W-3 -: MAN_W];
         end
      end
   end

endmodule

// File: rtl/fmul_share_ctrl.sv
// ---------------------------------------------------------------------------
// fmul_share_ctrl
// Shares one FMul_HalfPrecision datapath between two requesters. One
// operand pair is accepted at a time (round-robin on contention), held in
// operand registers for one EXEC cycle, and the product plus flags are
// captured into a response register returned on a tagged response channel.
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   reqN_valid / reqN_ready      : per-requester handshake (N = 0, 1)
//   reqN_a, reqN_b          16   : FP16 operands
//   rsp_valid / rsp_ready        : response handshake
//   rsp_id                  1    : requester the response belongs to
//   rsp_result              16   : FP16 product
//   rsp_overflow/underflow  1    : datapath exponent flags
//   busy                    1    : controller not in IDLE
// Parameter RR_INIT selects who wins the first contested arbitration.
// ---------------------------------------------------------------------------
module fmul_share_ctrl
   import fp16_pkg::*;
#(
   parameter logic RR_INIT = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [15:0]  req0_a,
   input  logic [15:0]  req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [15:0]  req1_a,
   input  logic [15:0]  req1_b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [15:0]  rsp_result,
   output logic         rsp_overflow,
   output logic         rsp_underflow,
   output logic         busy
);

   state_e           state_q, state_d;
   logic             prio_q, prio_d;
   logic [W-1:0]     op_a_q, op_a_d;
   logic [W-1:0]     op_b_q, op_b_d;
   logic             id_q, id_d;
   logic [W-1:0]     res_q, res_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             rid_q, rid_d;
   logic             grant0;
   logic             grant1;

   logic             dp_sign;
   logic [EXP_W-1:0] dp_exp;
   logic [MAN_W-1:0] dp_man;
   logic             dp_ovf;
   logic             dp_unf;

   // The datapath only ever sees the registered operands, so requester
   // inputs may change freely once their handshake has completed.
   FMul_HalfPrecision u_fmul (
      .a         (op_a_q),
      .b         (op_b_q),
      .sign      (dp_sign),
      .exponent  (dp_exp),
      .mantissa  (dp_man),
      .overflow  (dp_ovf),
      .underflow (dp_unf)
   );

   // Arbitration, FSM next state and register updates. A grant only exists
   // in IDLE and already implies valid, so ready == grant is the handshake.
   // prio flips to the other requester on every handshake, which lets a
   // lone requester be served repeatedly while a waiting one still wins
   // the next contested cycle.
   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      id_d    = id_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      rid_d   = rid_q;
      grant0  = 1'b0;
      grant1  = 1'b0;
      case (state_q)
         IDLE: begin
            grant0 = req0_valid & (!req1_valid | (prio_q == 1'b0));
            grant1 = req1_valid & (!req0_valid | (prio_q == 1'b1));
            if (grant0) begin
               op_a_d  = req0_a;
               op_b_d  = req0_b;
               id_d    = 1'b0;
               prio_d  = 1'b1;
               state_d = EXEC;
            end else if (grant1) begin
               op_a_d  = req1_a;
               op_b_d  = req1_b;
               id_d    = 1'b1;
               prio_d  = 1'b0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            res_d   = {dp_sign, dp_exp, dp_man};
            ovf_d   = dp_ovf;
            unf_d   = dp_unf;
            rid_d   = id_q;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and data registers. Reset drops any in-flight operation and
   // clears the response register so nothing stale can be presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         prio_q  <= RR_INIT;
         op_a_q  <= '0;
         op_b_q  <= '0;
         id_q    <= 1'b0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         rid_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         id_q    <= id_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         rid_q   <= rid_d;
      end
   end

   assign req0_ready    = grant0;
   assign req1_ready    = grant1;
   assign rsp_valid     = (state_q == RESP);
   assign rsp_id        = rid_q;
   assign rsp_result    = res_q;
   assign rsp_overflow  = ovf_q;
   assign rsp_underflow = unf_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_fmul_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fmul_share_ctrl
// Scenario tasks for the shared FP16 multiplier controller. Expected
// responses are pushed into a scoreboard queue when a handshake is seen and
// popped when the controller presents the response. All driving and
// sampling happens around the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fmul_share_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req0_ready;
   logic [15:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [15:0] req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [15:0] rsp_result;
   logic        rsp_overflow, rsp_underflow;
   logic        busy;

   typedef struct {
      logic        id;
      logic [15:0] res;
      logic        ovf;
      logic        unf;
      bit          chk_res;
      bit          chk_unf;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   fmul_share_ctrl #(.RR_INIT(1'b0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req0_valid    (req0_valid),
      .req0_ready    (req0_ready),
      .req0_a        (req0_a),
      .req0_b        (req0_b),
      .req1_valid    (req1_valid),
      .req1_ready    (req1_ready),
      .req1_a        (req1_a),
      .req1_b        (req1_b),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_result    (rsp_result),
      .rsp_overflow  (rsp_overflow),
      .rsp_underflow (rsp_underflow),
      .busy          (busy)
   );

   // Free-running 10 time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a scenario wedges.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic exp_t mk(input logic id, input logic [15:0] res,
                               input logic ovf, input logic unf,
                               input bit cr, input bit cu);
      exp_t e;
      e.id = id; e.res = res; e.ovf = ovf; e.unf = unf;
      e.chk_res = cr; e.chk_unf = cu;
      return e;
   endfunction

   // Present one operand pair and hold it until accepted (bounded), then
   // drop valid. Returns at the falling edge of the EXEC cycle.
   task automatic send(input logic id, input logic [15:0] a, input logic [15:0] b,
                       output bit ok);
      ok = 1'b0;
      @(negedge clk);
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
      for (int i = 0; i < 20; i++) begin
         #1;
         if ((id ? req1_ready : req0_ready) === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
   endtask

   // Wait (bounded) for rsp_valid; cyc counts falling edges crossed.
   task automatic wait_rsp(output bit ok, output int cyc);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (rsp_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0;
      rsp_ready  = 1'b1;
      #12;
      checks++; if (req0_ready !== 1'b0)     begin errors++; $display("[TB] FAIL reset_ready0 got=%b exp=0", req0_ready); end
      checks++; if (req1_ready !== 1'b0)     begin errors++; $display("[TB] FAIL reset_ready1 got=%b exp=0", req1_ready); end
      checks++; if (rsp_valid !== 1'b0)      begin errors++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (rsp_id !== 1'b0)         begin errors++; $display("[TB] FAIL reset_rsp_id got=%b exp=0", rsp_id); end
      checks++; if (rsp_result !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rsp_result got=%h exp=0000", rsp_result); end
      checks++; if (rsp_overflow !== 1'b0)   begin errors++; $display("[TB] FAIL reset_ovf got=%b exp=0", rsp_overflow); end
      checks++; if (rsp_underflow !== 1'b0)  begin errors++; $display("[TB] FAIL reset_unf got=%b exp=0", rsp_underflow); end
      checks++; if (busy !== 1'b0)           begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      // With both valid the RR_INIT holder (requester 0) is the one offered.
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("[TB] FAIL reset_rr_init got=%b exp=10", {req0_ready, req1_ready}); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_contention();
      int   grants[$];
      int   exp_g[4] = '{0, 1, 0, 1};
      exp_t e;
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 16'h3C00; req0_b = 16'h4000;
      req1_valid = 1'b1; req1_a = 16'h4000; req1_b = 16'h4000;
      for (int cyc = 0; cyc < 12; cyc++) begin
         #1;
         checks++;
         if ((req0_ready & req1_ready) !== 1'b0) begin errors++; $display("[TB] FAIL contention_one_ready cyc=%0d got=%b%b exp=not both", cyc, req0_ready, req1_ready); end
         if (req0_ready === 1'b1) begin grants.push_back(0); sb.push_back(mk(1'b0, 16'h4000, 1'b0, 1'b0, 1'b1, 1'b1)); end
         if (req1_ready === 1'b1) begin grants.push_back(1); sb.push_back(mk(1'b1, 16'h4400, 1'b0, 1'b0, 1'b1, 1'b1)); end
         if (rsp_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin errors++; $display("[TB] FAIL contention_sb got=response exp=none"); end
            else begin
               e = sb.pop_front();
               checks++; if (rsp_id !== e.id)         begin errors++; $display("[TB] FAIL contention_id got=%b exp=%b", rsp_id, e.id); end
               checks++; if (rsp_result !== e.res)    begin errors++; $display("[TB] FAIL contention_result got=%h exp=%h", rsp_result, e.res); end
               checks++; if (rsp_overflow !== e.ovf)  begin errors++; $display("[TB] FAIL contention_ovf got=%b exp=%b", rsp_overflow, e.ovf); end
               checks++; if (rsp_underflow !== e.unf) begin errors++; $display("[TB] FAIL contention_unf got=%b exp=%b", rsp_underflow, e.unf); end
            end
         end
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      checks++; if (grants.size() != 4) begin errors++; $display("[TB] FAIL contention_grant_count got=%0d exp=4", grants.size()); end
      for (int i = 0; i < 4 && i < grants.size(); i++) begin
         checks++; if (grants[i] != exp_g[i]) begin errors++; $display("[TB] FAIL contention_order idx=%0d got=%0d exp=%0d", i, grants[i], exp_g[i]); end
      end
      checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL contention_leftover got=%0d exp=0", sb.size()); end
      sb.delete();
   endtask

   task automatic test_single();
      bit   ok;
      int   cyc;
      exp_t e;
      send(1'b0, 16'h3E00, 16'h4000, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL single_accept got=%b exp=1", ok); end
      sb.push_back(mk(1'b0, 16'h4200, 1'b0, 1'b0, 1'b1, 1'b1));
      wait_rsp(ok, cyc);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL single_rsp_timeout got=%b exp=1", ok); end
      checks++; if (cyc != 1)    begin errors++; $display("[TB] FAIL single_latency got=%0d exp=1", cyc); end
      if (ok) begin
         e = sb.pop_front();
         checks++; if (rsp_id !== e.id)         begin errors++; $display("[TB] FAIL single_id got=%b exp=%b", rsp_id, e.id); end
         checks++; if (rsp_result !== e.res)    begin errors++; $display("[TB] FAIL single_result got=%h exp=%h", rsp_result, e.res); end
         checks++; if (rsp_overflow !== e.ovf)  begin errors++; $display("[TB] FAIL single_ovf got=%b exp=%b", rsp_overflow, e.ovf); end
         checks++; if (rsp_underflow !== e.unf) begin errors++; $display("[TB] FAIL single_unf got=%b exp=%b", rsp_underflow, e.unf); end
      end
      sb.delete();
      @(negedge clk);
   endtask

   task automatic test_sign();
      bit   ok;
      int   cyc;
      exp_t e;
      send(1'b1, 16'hBE00, 16'h4000, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL sign_accept got=%b exp=1", ok); end
      sb.push_back(mk(1'b1, 16'hC200, 1'b0, 1'b0, 1'b1, 1'b1));
      wait_rsp(ok, cyc);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL sign_rsp_timeout got=%b exp=1", ok); end
      if (ok) begin
         e = sb.pop_front();
         checks++; if (rsp_id !== e.id)        begin errors++; $display("[TB] FAIL sign_id got=%b exp=%b", rsp_id, e.id); end
         checks++; if (rsp_result !== e.res)   begin errors++; $display("[TB] FAIL sign_result got=%h exp=%h", rsp_result, e.res); end
         checks++; if (rsp_overflow !== e.ovf) begin errors++; $display("[TB] FAIL sign_ovf got=%b exp=%b", rsp_overflow, e.ovf); end
      end
      sb.delete();
      @(negedge clk);
   endtask

   task automatic test_zero_overflow();
      logic [15:0] ta[2] = '{16'h0000, 16'h7800};
      logic [15:0] tb[2] = '{16'h4000, 16'h7800};
      bit   ok;
      int   cyc;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         send(1'(i), ta[i], tb[i], ok);
         checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL zero_ovf_accept idx=%0d got=%b exp=1", i, ok); end
         // Zero product: result checked. Overflow: only the flags matter.
         if (i == 0) sb.push_back(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0));
         else        sb.push_back(mk(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1));
         wait_rsp(ok, cyc);
         checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL zero_ovf_rsp_timeout idx=%0d got=%b exp=1", i, ok); end
         if (ok) begin
            e = sb.pop_front();
            checks++; if (rsp_id !== e.id)       begin errors++; $display("[TB] FAIL zero_ovf_id idx=%0d got=%b exp=%b", i, rsp_id, e.id); end
            checks++; if (rsp_overflow !== e.ovf) begin errors++; $display("[TB] FAIL zero_ovf_ovf idx=%0d got=%b exp=%b", i, rsp_overflow, e.ovf); end
            if (e.chk_res) begin
               checks++; if (rsp_result !== e.res) begin errors++; $display("[TB] FAIL zero_ovf_result idx=%0d got=%h exp=%h", i, rsp_result, e.res); end
            end
            if (e.chk_unf) begin
               checks++; if (rsp_underflow !== e.unf) begin errors++; $display("[TB] FAIL zero_ovf_unf idx=%0d got=%b exp=%b", i, rsp_underflow, e.unf); end
            end
         end
         sb.delete();
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      bit   ok;
      int   cyc;
      exp_t e;
      rsp_ready = 1'b0;
      send(1'b0, 16'h3E00, 16'h4000, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL bp_accept got=%b exp=1", ok); end
      sb.push_back(mk(1'b0, 16'h4200, 1'b0, 1'b0, 1'b1, 1'b1));
      req1_valid = 1'b1; req1_a = 16'h4000; req1_b = 16'h4000;
      #1;
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_exec_ready1 got=%b exp=0", req1_ready); end
      wait_rsp(ok, cyc);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL bp_rsp_timeout got=%b exp=1", ok); end
      e = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
         checks++; if (rsp_valid !== 1'b1)                  begin errors++; $display("[TB] FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, rsp_valid); end
         checks++; if (rsp_result !== e.res)                begin errors++; $display("[TB] FAIL bp_hold_result cyc=%0d got=%h exp=%h", i, rsp_result, e.res); end
         checks++; if (rsp_id !== e.id)                     begin errors++; $display("[TB] FAIL bp_hold_id cyc=%0d got=%b exp=%b", i, rsp_id, e.id); end
         checks++; if ({req0_ready, req1_ready} !== 2'b00)  begin errors++; $display("[TB] FAIL bp_hold_ready cyc=%0d got=%b exp=00", i, {req0_ready, req1_ready}); end
         @(negedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      #1;
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_rsp_cycle_ready1 got=%b exp=0", req1_ready); end
      @(negedge clk);
      #1;
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_pending_ready1 got=%b exp=1", req1_ready); end
      sb.push_back(mk(1'b1, 16'h4400, 1'b0, 1'b0, 1'b1, 1'b1));
      @(negedge clk);
      req1_valid = 1'b0;
      wait_rsp(ok, cyc);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL bp_second_timeout got=%b exp=1", ok); end
      if (ok) begin
         e = sb.pop_front();
         checks++; if (rsp_id !== e.id)      begin errors++; $display("[TB] FAIL bp_second_id got=%b exp=%b", rsp_id, e.id); end
         checks++; if (rsp_result !== e.res) begin errors++; $display("[TB] FAIL bp_second_result got=%h exp=%h", rsp_result, e.res); end
      end
      sb.delete();
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit   ok;
      int   cyc;
      exp_t e;
      send(1'b0, 16'h3C00, 16'h4000, ok);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rmid_exec_busy got=%b exp=1", busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0)           begin errors++; $display("[TB] FAIL rmid_async_busy got=%b exp=0", busy); end
      checks++; if (rsp_result !== 16'h0000) begin errors++; $display("[TB] FAIL rmid_result_cleared got=%h exp=0000", rsp_result); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_no_rsp cyc=%0d got=%b exp=0", i, rsp_valid); end
      end
      send(1'b1, 16'hBE00, 16'h4000, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rmid_accept got=%b exp=1", ok); end
      sb.push_back(mk(1'b1, 16'hC200, 1'b0, 1'b0, 1'b1, 1'b1));
      wait_rsp(ok, cyc);
      checks++; if (cyc != 1) begin errors++; $display("[TB] FAIL rmid_latency got=%0d exp=1", cyc); end
      if (ok) begin
         e = sb.pop_front();
         checks++; if (rsp_id !== e.id)      begin errors++; $display("[TB] FAIL rmid_id got=%b exp=%b", rsp_id, e.id); end
         checks++; if (rsp_result !== e.res) begin errors++; $display("[TB] FAIL rmid_result got=%h exp=%h", rsp_result, e.res); end
      end
      sb.delete();
      @(negedge clk);
   endtask

   // Scenario sequence; contention runs right after reset so prio=RR_INIT.
   initial begin
      test_reset();
      test_contention();
      test_single();
      test_sign();
      test_zero_overflow();
      test_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
